// File: rtl/mc_pkg.sv
// mc_pkg: shared encodings for the multi-cycle MIPS control FSM.
//   State codes 0..12, opcode constants, and the AluOP / ALUSrcB /
//   PCSource field codes used by multicycle_control and mc_next_state.
package mc_pkg;

  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_MEMADR = 4'd2;
  localparam logic [3:0] S_MEMRD  = 4'd3;
  localparam logic [3:0] S_MEMWB  = 4'd4;
  localparam logic [3:0] S_MEMWR  = 4'd5;
  localparam logic [3:0] S_RTEXEC = 4'd6;
  localparam logic [3:0] S_RTWB   = 4'd7;
  localparam logic [3:0] S_BRANCH = 4'd8;
  localparam logic [3:0] S_JUMP   = 4'd9;
  localparam logic [3:0] S_IEXEC  = 4'd10;
  localparam logic [3:0] S_IWB    = 4'd11;
  localparam logic [3:0] S_EXC    = 4'd12;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_BLEZ  = 6'b000110;
  localparam logic [5:0] OP_BGTZ  = 6'b000111;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;
  localparam logic [1:0] ALU_IMM   = 2'b11;

  localparam logic [1:0] SRCB_RT   = 2'b00;
  localparam logic [1:0] SRCB_4    = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_IMM2 = 2'b11;

  localparam logic [1:0] PCS_ALU    = 2'b00;
  localparam logic [1:0] PCS_ALUOUT = 2'b01;
  localparam logic [1:0] PCS_JUMP   = 2'b10;

endpackage

// File: rtl/mc_next_state.sv
// mc_next_state: combinational next-state function of the control FSM.
//   i_state     current state code
//   i_opcode    IR opcode field
//   i_mem_ready memory handshake (only looked at in FETCH/MEMRD/MEMWR)
//   o_next      next state code
//   o_retire    this transition returns to FETCH having completed an instruction
// Macro MC_ILLEGAL_TRAP_EN: unknown opcodes trap to EXC instead of retiring as nop.
module mc_next_state
  import mc_pkg::*;
#(
  parameter int OPW = 6
) (
  input  logic [3:0]     i_state,
  input  logic [OPW-1:0] i_opcode,
  input  logic           i_mem_ready,
  output logic [3:0]     o_next,
  output logic           o_retire
);

  always_comb begin
    o_next   = S_FETCH;
    o_retire = 1'b0;
    case (i_state)
      S_FETCH:  o_next = i_mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (i_opcode)
          OPW'(OP_RTYPE):                  o_next = S_RTEXEC;
          OPW'(OP_LW), OPW'(OP_SW):        o_next = S_MEMADR;
          OPW'(OP_BEQ), OPW'(OP_BNE),
          OPW'(OP_BLEZ), OPW'(OP_BGTZ):    o_next = S_BRANCH;
          OPW'(OP_J):                      o_next = S_JUMP;
          OPW'(OP_ADDI), OPW'(OP_SLTI), OPW'(OP_ANDI),
          OPW'(OP_ORI), OPW'(OP_XORI), OPW'(OP_LUI):
                                           o_next = S_IEXEC;
          default: begin
`ifdef MC_ILLEGAL_TRAP_EN
            o_next = S_EXC;
`else
            // unknown opcode completes as a nop
            o_next   = S_FETCH;
            o_retire = 1'b1;
`endif
          end
        endcase
      end
      S_MEMADR: o_next = (i_opcode == OPW'(OP_LW)) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  o_next = i_mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWR: begin
        o_next   = i_mem_ready ? S_FETCH : S_MEMWR;
        o_retire = i_mem_ready;
      end
      S_RTEXEC: o_next = S_RTWB;
      S_IEXEC:  o_next = S_IWB;
      S_MEMWB, S_RTWB, S_BRANCH, S_JUMP, S_IWB: begin
        o_next   = S_FETCH;
        o_retire = 1'b1;
      end
      S_EXC:    o_next = S_EXC;  // only reset leaves the trap
      default:  o_next = S_FETCH;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: multi-cycle MIPS main control FSM.
//   clk, reset (sync, active high), opcode (IR[31:26]), mem_ready
//   Datapath controls: PCWrite, PCWriteCond, BrType, IorD, MemRead, MemWrite,
//   IRWrite, MemtoReg, RegWrite, RegDst, ALUSrcA, ALUSrcB, AluOP, PCSource
//   Debug/status: state_o, retired (wrapping retire count), illegal (trap build only)
// Macro MC_ILLEGAL_TRAP_EN: adds EXC state and the illegal output.
module multicycle_control
  import mc_pkg::*;
#(
  parameter int OPW    = 6,
  parameter int ALUOPW = 2,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [OPW-1:0]    opcode,
  input  logic              mem_ready,
  output logic              PCWrite,
  output logic              PCWriteCond,
  output logic [1:0]        BrType,
  output logic              IorD,
  output logic              MemRead,
  output logic              MemWrite,
  output logic              IRWrite,
  output logic              MemtoReg,
  output logic              RegWrite,
  output logic              RegDst,
  output logic              ALUSrcA,
  output logic [1:0]        ALUSrcB,
  output logic [ALUOPW-1:0] AluOP,
  output logic [1:0]        PCSource,
  output logic [3:0]        state_o,
  output logic [CNT_W-1:0]  retired
`ifdef MC_ILLEGAL_TRAP_EN
  ,
  output logic              illegal
`endif
);

  logic [3:0]       r_state;
  logic [CNT_W-1:0] r_retired;
  logic [3:0]       w_next;
  logic             w_retire;

  mc_next_state #(.OPW(OPW)) u_ns (
    .i_state     (r_state),
    .i_opcode    (opcode),
    .i_mem_ready (mem_ready),
    .o_next      (w_next),
    .o_retire    (w_retire)
  );

  // reset wins over the retire strobe, so an abandoned instruction never counts
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_FETCH;
      r_retired <= '0;
    end else begin
      r_state <= w_next;
      if (w_retire) r_retired <= r_retired + CNT_W'(1);
    end
  end

  assign retired = r_retired;
  assign state_o = reset ? 4'd0 : r_state;
`ifdef MC_ILLEGAL_TRAP_EN
  assign illegal = !reset && (r_state == S_EXC);
`endif

  // Moore decode; controls are held low for the whole reset cycle
  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    BrType      = 2'b00;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    RegWrite    = 1'b0;
    RegDst      = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = SRCB_RT;
    AluOP       = ALUOPW'(ALU_ADD);
    PCSource    = PCS_ALU;
    if (!reset) begin
      case (r_state)
        S_FETCH: begin
          MemRead = 1'b1;
          ALUSrcB = SRCB_4;
          // IR and PC+4 commit only on the cycle the fetch completes
          IRWrite = mem_ready;
          PCWrite = mem_ready;
        end
        S_DECODE: ALUSrcB = SRCB_IMM2;
        S_MEMADR: begin
          ALUSrcA = 1'b1;
          ALUSrcB = SRCB_IMM;
        end
        S_MEMRD: begin
          MemRead = 1'b1;
          IorD    = 1'b1;
        end
        S_MEMWB: begin
          RegWrite = 1'b1;
          MemtoReg = 1'b1;
        end
        S_MEMWR: begin
          MemWrite = 1'b1;
          IorD     = 1'b1;
        end
        S_RTEXEC: begin
          ALUSrcA = 1'b1;
          AluOP   = ALUOPW'(ALU_FUNCT);
        end
        S_RTWB: begin
          RegWrite = 1'b1;
          RegDst   = 1'b1;
        end
        S_BRANCH: begin
          ALUSrcA     = 1'b1;
          AluOP       = ALUOPW'(ALU_SUB);
          PCWriteCond = 1'b1;
          PCSource    = PCS_ALUOUT;
          BrType      = opcode[1:0];
        end
        S_JUMP: begin
          PCWrite  = 1'b1;
          PCSource = PCS_JUMP;
        end
        S_IEXEC: begin
          ALUSrcA = 1'b1;
          ALUSrcB = SRCB_IMM;
          if (opcode == OPW'(OP_ADDI))      AluOP = ALUOPW'(ALU_ADD);
          else if (opcode == OPW'(OP_SLTI)) AluOP = ALUOPW'(ALU_SUB);
          else                              AluOP = ALUOPW'(ALU_IMM);
        end
        S_IWB:   RegWrite = 1'b1;
        default: ;
      endcase
    end
  end

endmodule
